cad_out_serializer: RTL



---
 rtl/cad_out_serializer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cad_out_serializer.sv
// -----------------------------------------------------------------------------
// cad_out_serializer
//
// Output stage of the CAD convolution/deconvolution engine. Signed result
// words from the compute core are buffered in a small FIFO and emitted as
// one contiguous serial stream per frame. Each word is sent LSB first over
// DATA_W cycles, and words follow each other with no gap.
//
// Handshake: a word moves from the core into the FIFO on every rising edge
// where in_valid and in_ready are both 1. The core keeps in_valid and in_data
// stable until that happens. in_ready does not depend combinationally on
// in_valid.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        single-cycle frame open pulse, honoured only in IDLE
//   word_cnt     words in the frame, sampled with start (0 = ignored)
//   in_valid     core presents in_data
//   in_data      two's complement result word, passed through bit-exact
//   in_ready     block accepts in_data this cycle
//   out_valid    serial output qualifier
//   out_value    serial output bit (0 whenever out_valid is 0)
//   busy         high from the accepted start until the frame completes
//   done         one-cycle pulse after the last bit of a frame
//   underrun     sticky: FIFO was empty at a word boundary mid-frame
//   o_dbg_state  current FSM state (IDLE=0, FILL=1, SHIFT=2, DONE=3)
// -----------------------------------------------------------------------------
module cad_out_serializer #(
   parameter int DATA_W     = 20,
   parameter int FIFO_DEPTH = 4,
   parameter int PRELOAD    = 2,
   parameter int CNT_W      = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  word_cnt,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic              out_value,
   output logic              busy,
   output logic              done,
   output logic              underrun,
   output logic [1:0]        o_dbg_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W = PTR_W + 1;
   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
   logic [LVL_W-1:0]   r_wr_ptr;
   logic [LVL_W-1:0]   r_rd_ptr;
   logic [DATA_W-1:0]  r_shreg;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [CNT_W-1:0]   r_rem_in;
   logic [CNT_W-1:0]   r_rem_out;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_out_value;
   logic               r_busy;
   logic               r_done;
   logic               r_underrun;

   logic [LVL_W-1:0]   w_level;
   logic [LVL_W-1:0]   w_level_nxt;
   logic               w_empty;
   logic               w_full_nxt;
   logic [DATA_W-1:0]  w_head;
   logic               w_push;
   logic               w_pop;
   logic [CNT_W-1:0]   w_need;
   logic               w_fill_go;
   logic               w_last_bit;
   logic               w_word_end;
   logic               w_frame_end;
   logic               w_start_ok;
   logic [CNT_W-1:0]   w_rem_in_nxt;
   logic               w_busy_nxt;
   logic               w_in_ready_nxt;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      w_level     = r_wr_ptr - r_rd_ptr;
      w_empty     = (w_level == '0);
      w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];
      w_push      = in_valid & r_in_ready;

      // A short frame may never reach PRELOAD words, so only wait for
      // what is still owed.
      w_need      = (r_rem_out < CNT_W'(PRELOAD)) ? r_rem_out : CNT_W'(PRELOAD);
      w_fill_go   = (r_state == S_FILL) && !w_empty && (CNT_W'(w_level) >= w_need);

      w_last_bit  = (r_bit_cnt == BIT_W'(DATA_W - 1));
      w_word_end  = (r_state == S_SHIFT) && w_last_bit;
      w_frame_end = w_word_end && (r_rem_out == CNT_W'(1));
      w_pop       = w_fill_go || (w_word_end && !w_frame_end && !w_empty);

      w_start_ok  = (r_state == S_IDLE) && start && (word_cnt != '0);

      w_level_nxt    = w_level + LVL_W'(w_push) - LVL_W'(w_pop);
      w_full_nxt     = (w_level_nxt == LVL_W'(FIFO_DEPTH));
      w_rem_in_nxt   = w_start_ok ? word_cnt : (r_rem_in - CNT_W'(w_push));
      w_busy_nxt     = w_start_ok || (r_busy && !w_frame_end);
      // in_ready is registered, so it is computed from next-cycle values.
      w_in_ready_nxt = w_busy_nxt && !w_full_nxt && (w_rem_in_nxt != '0);
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_rem_in    <= '0;
         r_rem_out   <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_value <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_busy     <= w_busy_nxt;
         r_rem_in   <= w_rem_in_nxt;
         r_in_ready <= w_in_ready_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);

         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_rem_out <= word_cnt;
                  r_state   <= S_FILL;
               end
            end

            S_FILL: begin
               if (w_fill_go) begin
                  // Bit 0 goes straight to the output; the rest waits in shreg.
                  r_out_valid <= 1'b1;
                  r_out_value <= w_head[0];
                  r_shreg     <= w_head >> 1;
                  r_bit_cnt   <= '0;
                  r_state     <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (!w_last_bit) begin
                  r_out_value <= r_shreg[0];
                  r_shreg     <= r_shreg >> 1;
                  r_bit_cnt   <= r_bit_cnt + BIT_W'(1);
               end else begin
                  r_rem_out <= r_rem_out - CNT_W'(1);
                  if (w_frame_end) begin
                     r_out_valid <= 1'b0;
                     r_out_value <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (!w_empty) begin
                     r_out_value <= w_head[0];
                     r_shreg     <= w_head >> 1;
                     r_bit_cnt   <= '0;
                  end else begin
                     // Core fell behind: flag it, drop the qualifier and wait
                     // for more words. The stream is already broken.
                     r_underrun  <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_out_value <= 1'b0;
                     r_state     <= S_FILL;
                  end
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_value   = r_out_value;
   assign busy        = r_busy;
   assign done        = r_done;
   assign underrun    = r_underrun;
   assign o_dbg_state = r_state;

endmodule
